// File: rtl/mem_sched_pkg.sv
// Shared types and grant policy for the DDR read/write scheduler.
// Keeping pick_dir pure lets the direction policy be exercised in isolation.
package mem_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StZlen,
    StGap
  } sched_state_e;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  localparam int unsigned STREAK_BITS = 4;
  localparam int unsigned BUSY_BITS   = 13;

  // A lone requester always wins; with both pending, stay on the current
  // direction until its run reaches run_max, then hand over.
  function automatic logic pick_dir(input logic                   req_rd,
                                    input logic                   req_wr,
                                    input logic                   last_dir,
                                    input logic [STREAK_BITS-1:0] streak,
                                    input logic [STREAK_BITS-1:0] run_max);
    if (req_rd && !req_wr) return DIR_RD;
    if (req_wr && !req_rd) return DIR_WR;
    if (streak < run_max) return last_dir;
    return ~last_dir;
  endfunction

endpackage

// File: rtl/mem_rw_sched.sv
// Grants one burst at a time to the burst engine, favouring same-direction runs,
// completing zero-length bursts locally and flagging bursts that never finish.
module mem_rw_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned RUN_MAX       = 4,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     calib_done,
  input  logic                     s_rd_burst_req,
  input  logic [9:0]               s_rd_burst_len,
  input  logic [23:0]              s_rd_burst_addr,
  output logic                     s_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] s_rd_burst_data,
  output logic                     s_rd_burst_finish,
  input  logic                     s_wr_burst_req,
  input  logic [9:0]               s_wr_burst_len,
  input  logic [23:0]              s_wr_burst_addr,
  output logic                     s_wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] s_wr_burst_data,
  output logic                     s_wr_burst_finish,
  output logic                     m_rd_burst_req,
  output logic [9:0]               m_rd_burst_len,
  output logic [23:0]              m_rd_burst_addr,
  input  logic                     m_rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] m_rd_burst_data,
  input  logic                     m_rd_burst_finish,
  output logic                     m_wr_burst_req,
  output logic [9:0]               m_wr_burst_len,
  output logic [23:0]              m_wr_burst_addr,
  input  logic                     m_wr_burst_data_req,
  input  logic                     m_wr_burst_finish,
  output logic [MEM_DATA_BITS-1:0] m_wr_burst_data,
  output logic [15:0]              rd_burst_cnt,
  output logic [15:0]              wr_burst_cnt,
  output logic                     err_timeout
);

  localparam logic [STREAK_BITS-1:0] RunMaxW   = STREAK_BITS'(RUN_MAX);
  localparam logic [BUSY_BITS-1:0]   BusyLimit = BUSY_BITS'(TIMEOUT - 1);

  sched_state_e           state_q, state_d;
  logic                   last_dir_q, last_dir_d;
  logic [STREAK_BITS-1:0] streak_q, streak_d;
  logic [9:0]             len_q, len_d;
  logic [23:0]            addr_q, addr_d;
  logic [BUSY_BITS-1:0]   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [15:0]            rd_cnt_q, rd_cnt_d;
  logic [15:0]            wr_cnt_q, wr_cnt_d;

  logic        dir_sel;
  logic [9:0]  sel_len;
  logic [23:0] sel_addr;
  logic        in_rd, in_wr, zlen_rd, zlen_wr;

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    streak_d   = streak_q;
    len_d      = len_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    err_d      = err_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;

    dir_sel  = pick_dir(s_rd_burst_req, s_wr_burst_req, last_dir_q, streak_q, RunMaxW);
    sel_len  = (dir_sel == DIR_WR) ? s_wr_burst_len  : s_rd_burst_len;
    sel_addr = (dir_sel == DIR_WR) ? s_wr_burst_addr : s_rd_burst_addr;

    // Busy time only accrues while a real burst is open; never aborted here.
    if (state_q == StRd || state_q == StWr) begin
      if (busy_q != '1) busy_d = busy_q + 1'b1;
      if (busy_q >= BusyLimit) err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (calib_done && (s_rd_burst_req || s_wr_burst_req)) begin
          last_dir_d = dir_sel;
          if (dir_sel != last_dir_q)   streak_d = STREAK_BITS'(1);
          else if (streak_q < RunMaxW) streak_d = streak_q + 1'b1;
          else                         streak_d = RunMaxW;
          busy_d = '0;
          if (sel_len == '0) begin
            state_d = StZlen;
          end else begin
            state_d = (dir_sel == DIR_WR) ? StWr : StRd;
            len_d   = sel_len;
            addr_d  = sel_addr;
          end
        end
      end
      StRd: begin
        if (m_rd_burst_finish) begin
          state_d  = StGap;
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      StWr: begin
        if (m_wr_burst_finish) begin
          state_d  = StGap;
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end
      StZlen:  state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_dir_q <= DIR_RD;
      streak_q   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      streak_q   <= streak_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign in_rd   = (state_q == StRd);
  assign in_wr   = (state_q == StWr);
  assign zlen_rd = (state_q == StZlen) && (last_dir_q == DIR_RD);
  assign zlen_wr = (state_q == StZlen) && (last_dir_q == DIR_WR);

  assign m_rd_burst_req  = in_rd;
  assign m_rd_burst_len  = len_q;
  assign m_rd_burst_addr = addr_q;
  assign m_wr_burst_req  = in_wr;
  assign m_wr_burst_len  = len_q;
  assign m_wr_burst_addr = addr_q;

  // Data path is purely combinational and gated by the granted direction.
  assign s_rd_burst_data_valid = in_rd & m_rd_burst_data_valid;
  assign s_rd_burst_data       = in_rd ? m_rd_burst_data : '0;
  assign s_rd_burst_finish     = (in_rd & m_rd_burst_finish) | zlen_rd;
  assign s_wr_burst_data_req   = in_wr & m_wr_burst_data_req;
  assign s_wr_burst_finish     = (in_wr & m_wr_burst_finish) | zlen_wr;
  assign m_wr_burst_data       = in_wr ? s_wr_burst_data : '0;

  assign rd_burst_cnt = rd_cnt_q;
  assign wr_burst_cnt = wr_cnt_q;
  assign err_timeout  = err_q;

endmodule

// File: doc/mem_rw_sched.md
# mem_rw_sched

Read/write scheduler between the write arbiter, the read arbiter and the single burst engine (mem_burst_v2) in the DDR controller. Grants at most one burst at a time to the burst engine. Favours runs of same-direction bursts to cut bus turnaround, with a bounded run length so neither direction starves. Also completes zero-length bursts locally, gates all traffic on calibration, and flags hung bursts.

## Interface
Parameters:
- MEM_DATA_BITS, 64, burst data width
- RUN_MAX, 4, max consecutive same-direction grants while the other direction waits (1..15)
- TIMEOUT, 4096, cycles a granted burst may stay open before err_timeout sets

Ports (upstream = arbiter side `s_`, downstream = burst engine side `m_`):
- mem_clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- calib_done  in  1  memory calibrated; no grant while low
- s_rd_burst_req / s_rd_burst_len / s_rd_burst_addr  in  1/10/24  read request, held until s_rd_burst_finish
- s_rd_burst_data_valid, s_rd_burst_data, s_rd_burst_finish  out  1/MEM_DATA_BITS/1  read return
- s_wr_burst_req / s_wr_burst_len / s_wr_burst_addr  in  1/10/24  write request, held until s_wr_burst_finish
- s_wr_burst_data_req  out  1  write data request; s_wr_burst_data  in  MEM_DATA_BITS
- s_wr_burst_finish  out  1  write done
- m_rd_burst_req, m_rd_burst_len, m_rd_burst_addr  out  1/10/24  to burst engine
- m_rd_burst_data_valid, m_rd_burst_data, m_rd_burst_finish  in  1/MEM_DATA_BITS/1
- m_wr_burst_req, m_wr_burst_len, m_wr_burst_addr  out  1/10/24  to burst engine
- m_wr_burst_data_req, m_wr_burst_finish  in  1/1
- m_wr_burst_data  out  MEM_DATA_BITS  to burst engine
- rd_burst_cnt, wr_burst_cnt  out  16/16  completed-burst counters, wrap at 0xFFFF to 0
- err_timeout  out  1  sticky; cleared only by rst

## Operation
- States: IDLE, RD, WR, ZLEN, GAP.
- IDLE, calib_done low: stay in IDLE.
- IDLE, exactly one request: select it.
- IDLE, both requesting: keep last_dir if streak < RUN_MAX, else switch.
- On select:
  - last_dir changes → streak = 1.
  - last_dir unchanged → streak increments, saturating at RUN_MAX.
- Selected request with len == 0 → ZLEN. No downstream request; the matching s_*_finish pulses for one cycle. ZLEN counts toward streak, not toward the counters.
- Selected request with len != 0 → RD or WR. Latch len/addr; drive m_*_burst_req high.
- In RD: m_rd data_valid/data/finish pass combinationally to the s_rd side. s_wr outputs stay 0.
- In WR: m_wr_burst_data_req and finish pass combinationally to s_wr. s_wr_burst_data passes to m_wr_burst_data. s_rd outputs stay 0.
- Finish seen in RD/WR → GAP, and the matching counter increments.
- ZLEN → GAP. GAP → IDLE unconditionally. GAP exists so the arbiter can drop its request.
- Busy counter counts cycles in RD/WR and clears on entry. Reaching TIMEOUT sets err_timeout. The burst is not aborted; the state keeps waiting for finish.
- Reset values:
  - state IDLE, last_dir = RD, streak = 0.
  - All m_*_req, s_*_finish and counters 0; err_timeout 0.
- Reset mid-burst: return to IDLE immediately. The burst engine shares rst; no finish is generated.
- Downstream finish while in IDLE/GAP/ZLEN: ignored, not forwarded, not counted.

## Timing
- Request sampled in IDLE at cycle N → m_*_burst_req high at N+1. len/addr are stable from N+1 until deassert.
- m_*_burst_finish at cycle M:
  - s_*_finish at M (combinational).
  - m_*_burst_req low at M+1 (state GAP).
  - IDLE at M+2; earliest next m_*_burst_req at M+3.
- Zero-length request sampled at N → s_*_finish high at N+1 only; IDLE at N+3.
- Data path adds no latency; the only registered elements are grant, len/addr latch and counters.
- m_rd_burst_req and m_wr_burst_req are never high together.

## Structure
- Shared package mem_sched_pkg holds:
  - state encoding (IDLE, RD, WR, ZLEN, GAP);
  - direction constants DIR_RD = 0, DIR_WR = 1;
  - a pure pick function (req_rd, req_wr, last_dir, streak, RUN_MAX) → direction, so the policy can be unit-tested.
- Single module; no sub-modules. The timeout counter is 13 bits, saturating.

## Test plan
- calib_done = 0, read request held 50 cycles → m_rd_burst_req stays 0. Raise calib_done → m_rd_burst_req high 1 cycle after sampling.
- Read len = 16, engine returns 16 valids then finish → all 16 data forwarded unchanged, s_rd_burst_finish aligned, rd_burst_cnt = 1.
- Reads and writes both continuously requesting, RUN_MAX = 4 → grant order R,R,R,R,W,W,W,W,R…; only one m_req high at any cycle.
- Write len = 0 → no m_wr_burst_req; one-cycle s_wr_burst_finish 1 cycle after sampling; wr_burst_cnt unchanged.
- Engine never finishes a write → err_timeout set after 4096 cycles. It persists after a late finish and clears only on rst.
- rst asserted mid-read (cycle 5 of 16) → next cycle all outputs 0, state IDLE. A fresh request after reset is granted normally.
